// File: rtl/change_dispenser_if.sv
// Handshake and coin-eject bundle between a vending controller and the change dispenser.
interface change_dispenser_if;
  logic       start;
  logic [3:0] amount;
  logic       ready;
  logic       busy;
  logic       coin5;
  logic       coin2;
  logic       coin1;
  logic [3:0] remaining;
  logic [2:0] coin_count;
  logic       done;

  modport master (
    output start, amount,
    input  ready, busy, coin5, coin2, coin1, remaining, coin_count, done
  );

  modport slave (
    input  start, amount,
    output ready, busy, coin5, coin2, coin1, remaining, coin_count, done
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy 5/2/1 change dispenser: one timed eject pulse per coin, each followed by a gap,
// then a single-cycle done. All outputs are registered.
module change_dispenser #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input logic              clk,
  input logic              rst_n,
  change_dispenser_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} state_t;

  localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_ready;
  logic       r_busy;
  logic       r_coin5;
  logic       r_coin2;
  logic       r_coin1;
  logic [3:0] r_remaining;
  logic [2:0] r_coinCount;
  logic       r_done;

  logic [3:0] w_coinVal;
  logic [2:0] w_selAmount;
  logic [2:0] w_selRemain;

  // Returns {coin5, coin2, coin1}; never picks a coin larger than the value.
  function automatic logic [2:0] pickCoin(input logic [3:0] value);
    if (value >= 4'd5)      pickCoin = 3'b100;
    else if (value >= 4'd2) pickCoin = 3'b010;
    else                    pickCoin = 3'b001;
  endfunction

  assign w_coinVal   = r_coin5 ? 4'd5 : (r_coin2 ? 4'd2 : 4'd1);
  assign w_selAmount = pickCoin(bus.amount);
  assign w_selRemain = pickCoin(r_remaining);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_coin5     <= 1'b0;
      r_coin2     <= 1'b0;
      r_coin1     <= 1'b0;
      r_remaining <= 4'd0;
      r_coinCount <= 3'd0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_remaining <= bus.amount;
            r_coinCount <= 3'd0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b1;
            if (bus.amount != 4'd0) begin
              r_state                     <= PULSE;
              {r_coin5, r_coin2, r_coin1} <= w_selAmount;
              r_cnt                       <= PULSE_LAST;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        PULSE: begin
          if (r_cnt == 4'd0) begin
            r_remaining                 <= r_remaining - w_coinVal;
            r_coinCount                 <= r_coinCount + 3'd1;
            {r_coin5, r_coin2, r_coin1} <= 3'b000;
            r_cnt                       <= GAP_LAST;
            r_state                     <= GAP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        GAP: begin
          // The next coin is chosen from the already-decremented remaining value.
          if (r_cnt == 4'd0) begin
            if (r_remaining != 4'd0) begin
              r_state                     <= PULSE;
              {r_coin5, r_coin2, r_coin1} <= w_selRemain;
              r_cnt                       <= PULSE_LAST;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready      = r_ready;
  assign bus.busy       = r_busy;
  assign bus.coin5      = r_coin5;
  assign bus.coin2      = r_coin2;
  assign bus.coin1      = r_coin1;
  assign bus.remaining  = r_remaining;
  assign bus.coin_count = r_coinCount;
  assign bus.done       = r_done;

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL provide parameter PULSE_CYCLES, default 4: cycles each coin-eject output is held high; legal range 1..15.
REQ-002 SHALL provide parameter GAP_CYCLES, default 2: low cycles after each coin pulse; legal range 1..15.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL provide port start  input  1  request to dispense `amount`; sampled only while ready=1.
REQ-006 SHALL provide port amount  input  4  change value in coin units, 0..15.
REQ-007 SHALL provide port ready  output  1  high only in IDLE; start is accepted in this state.
REQ-008 SHALL provide port busy  output  1  high in every state except IDLE.
REQ-009 SHALL provide port coin5  output  1  eject one 5-unit coin while high.
REQ-010 SHALL provide port coin2  output  1  eject one 2-unit coin while high.
REQ-011 SHALL provide port coin1  output  1  eject one 1-unit coin while high.
REQ-012 SHALL provide port remaining  output  4  units still to dispense.
REQ-013 SHALL provide port coin_count  output  3  coins ejected in the current or last transaction.
REQ-014 SHALL provide port done  output  1  one-cycle pulse at transaction end.

Function
REQ-015 SHALL implement states IDLE, PULSE, GAP, DONE; all outputs SHALL be registered.
REQ-016 In IDLE with start=1: remaining<=amount; coin_count<=0; next state PULSE if amount!=0, else DONE.
REQ-017 Coin selection SHALL be greedy, fixed at entry to PULSE: remaining>=5 gives coin5, else remaining>=2 gives coin2, else coin1.
REQ-018 In PULSE: exactly one coin output high for exactly PULSE_CYCLES consecutive cycles; other coin outputs low.
REQ-019 On the last PULSE cycle: remaining<=remaining minus the coin value; coin_count<=coin_count+1; next state GAP.
REQ-020 In GAP: all coin outputs low for exactly GAP_CYCLES cycles; then PULSE if remaining!=0, else DONE.
REQ-021 In DONE: done=1 for exactly one cycle; next state IDLE; ready=1 from the following cycle.
REQ-022 start SHALL be ignored while busy=1; amount SHALL be ignored except on the accepting edge.
REQ-023 remaining SHALL never underflow; the greedy rule guarantees the coin value is <= remaining.
REQ-024 Timing SHALL be exact: start accepted at edge 0, first coin high from cycle 1, done at cycle 1+N*(PULSE_CYCLES+GAP_CYCLES) for N coins.
REQ-025 For amount=0: done SHALL assert at cycle 1, no coin output SHALL assert, and coin_count SHALL stay 0.
REQ-026 The maximum transaction (amount=15) SHALL produce 3 coins; coin_count SHALL hold values up to 5 without wrap.
REQ-027 coin_count and remaining SHALL hold their final values in IDLE until the next accepted start.

Reset
REQ-028 With rst_n=0 at a rising edge: state<=IDLE, coin outputs<=0, done<=0, busy<=0, remaining<=0, coin_count<=0; ready=1 from the next cycle.
REQ-029 Reset in any state, including mid-pulse, SHALL abort the transaction immediately at that edge and SHALL NOT complete the coin or generate done.
REQ-030 With rst_n=0, start SHALL be ignored.

Verification
REQ-031 amount=7, defaults -> coin5 high cycles 1-4, coin2 high cycles 7-10, done at cycle 13, coin_count=2, remaining=0, ready at cycle 14.
REQ-032 amount=0 -> done at cycle 1, no coin pulse, coin_count=0.
REQ-033 amount=15 -> three coin5 pulses, done at cycle 19, coin_count=3.
REQ-034 amount=4; start re-asserted with amount=9 during busy -> request ignored; two coin2 pulses; remaining=0; done at cycle 13.
REQ-035 amount=1; rst_n=0 during cycle 2 -> coin1 low and busy=0 after that edge, no done, ready=1 next cycle.
REQ-036 PULSE_CYCLES=1, GAP_CYCLES=1, amount=3 -> coin2 at cycle 1, coin1 at cycle 3, done at cycle 5.
